// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_pkg
// Description : Shared widths and types for the 256-bit stream output path.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_pkg;

    localparam int STREAM_W   = 256;
    localparam int BEAT_W     = 64;
    localparam int BEATS      = 4;
    localparam int BEAT_IDX_W = $clog2(BEATS);
    localparam int DROP_CNT_W = 16;

    typedef struct packed {
        logic [STREAM_W-1:0] data;
        logic                send;
    } stream_word_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOADED = 1'b1
    } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/stream_buf_fifo.sv
`default_nettype none
// ============================================================================
// Module      : stream_buf_fifo
// Description : DEPTH-entry circular buffer of stream words with level count.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_buf_fifo
    import stream_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push_req,
    input  stream_word_t       i_push_word,
    input  logic               i_pop,
    output stream_word_t       o_rd_word,
    output logic [LVL_W-1:0]   o_level,
    output logic [LVL_W-1:0]   o_level_next,
    output logic               o_drop
);

    localparam int PTR_W = $clog2(DEPTH);

    stream_word_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;

    logic w_full;
    logic w_pop;
    logic w_push;
    logic [LVL_W-1:0] w_level_next;

    assign w_full = (r_level == LVL_W'(DEPTH));
    assign w_pop  = i_pop && (r_level != '0);
    // A pop on the same edge frees a slot, so a write at full is still taken.
    assign w_push = i_push_req && (!w_full || w_pop);

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + LVL_W'(1);
        end else if (w_pop && !w_push) begin
            w_level_next = r_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level <= w_level_next;
        end
    end

    assign o_rd_word    = r_mem[r_rd_ptr];
    assign o_level      = r_level;
    assign o_level_next = w_level_next;
    assign o_drop       = i_push_req && w_full && !w_pop;

endmodule
`default_nettype wire

// File: rtl/stream_serializer_256to64.sv
`default_nettype none
// ============================================================================
// Module      : stream_serializer_256to64
// Description : Buffers 256-bit words and emits them as four 64-bit beats.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_serializer_256to64
    import stream_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic [STREAM_W-1:0]         fifo_data,
    input  logic                        fifo_write,
    input  logic                        fifo_send,
    output logic [BEAT_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        fifo_almost_full,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        overflow,
    output logic [DROP_CNT_W-1:0]       drop_count,
    input  logic                        stat_clear
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [BEAT_IDX_W-1:0] C_LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

    stream_word_t           w_push_word;
    stream_word_t           w_rd_word;
    logic [LVL_W-1:0]       w_level;
    logic [LVL_W-1:0]       w_level_next;
    logic                   w_drop;
    logic                   w_xfer;
    logic                   w_last_xfer;
    logic                   w_pop;

    ser_state_t             r_state;
    logic [STREAM_W-1:0]    r_word;
    logic                   r_send;
    logic [BEAT_IDX_W-1:0]  r_beat;
    logic                   r_af;
    logic                   r_overflow;
    logic [DROP_CNT_W-1:0]  r_drop_count;

    assign w_push_word.data = fifo_data;
    assign w_push_word.send = fifo_send;

    assign w_xfer      = (r_state == ST_LOADED) && out_ready;
    assign w_last_xfer = w_xfer && (r_beat == C_LAST_BEAT);
    // Reloading on the final beat transfer keeps the output free of bubbles.
    assign w_pop       = ((r_state == ST_IDLE) || w_last_xfer) && (w_level != '0);

    stream_buf_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_buf (
        .clk          (clk_clk),
        .rst_n        (reset_reset_n),
        .i_push_req   (fifo_write),
        .i_push_word  (w_push_word),
        .i_pop        (w_pop),
        .o_rd_word    (w_rd_word),
        .o_level      (w_level),
        .o_level_next (w_level_next),
        .o_drop       (w_drop)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_send  <= 1'b0;
            r_beat  <= '0;
        end else begin
            if (w_pop) begin
                r_state <= ST_LOADED;
                r_word  <= w_rd_word.data;
                r_send  <= w_rd_word.send;
                r_beat  <= '0;
            end else if (w_xfer) begin
                r_beat <= r_beat + BEAT_IDX_W'(1);
                if (r_beat == C_LAST_BEAT) begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_af         <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_af <= (w_level_next >= LVL_W'(AF_LEVEL));
            if (stat_clear) begin
                r_overflow   <= 1'b0;
                r_drop_count <= '0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != '1) begin
                    r_drop_count <= r_drop_count + DROP_CNT_W'(1);
                end
            end
        end
    end

    assign out_data         = r_word[r_beat*BEAT_W +: BEAT_W];
    assign out_valid        = (r_state == ST_LOADED);
    assign out_last         = r_send && (r_beat == C_LAST_BEAT);
    assign fifo_almost_full = r_af;
    assign level            = w_level;
    assign overflow         = r_overflow;
    assign drop_count       = r_drop_count;

endmodule
`default_nettype wire
